// File: rtl/vliw_scoreboard.sv
// -----------------------------------------------------------------------------
// vliw_scoreboard
//
// Issue-hazard scoreboard for the multi-lane VLIW datapath. It sits between
// instruction decode and the functional-unit issue registers and tracks which
// architectural registers still have a result in flight in one of the
// variable-latency units.
//
// Each register r owns a small countdown cnt[r]. A fired bundle loads the
// countdown of every destination it writes with the unit latency (0 is
// treated as 1). The register stays busy while its countdown is nonzero.
// There is no bypass: a register is still busy in the cycle its countdown
// reads 1.
//
// A bundle stalls (issue_ready=0) when any active lane reads a busy register
// (RAW) or writes a busy register (WAW). Sources are compared against the
// pre-bundle busy state, so a lane may read another lane's destination in the
// same bundle without stalling. A bundle in which two active lanes write the
// same nonzero register still fires, but it marks nothing busy and raises
// illegal for one cycle.
//
// Handshake: issue_valid/issue_ready. A bundle is consumed in any cycle where
// issue_fire = issue_valid & issue_ready is high at the rising clock edge;
// issue_ready does not depend on issue_valid and is forced low during reset.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   issue_valid    a bundle is presented this cycle
//   issue_lane_en  per-lane slot-used flags
//   issue_dst      destination register per lane, lane k at [k*REGW +: REGW]
//   issue_src1     first source register per lane
//   issue_src2     second source register per lane
//   issue_lat      unit latency per lane, lane k at [k*LATW +: LATW]
//   issue_ready    combinational: bundle may fire this cycle
//   issue_fire     combinational: issue_valid & issue_ready
//   illegal        registered one-cycle pulse after a duplicate-destination fire
//   busy_vec       registered: bit r set while register r has a pending write
//   stall_count    registered: saturating count of stalled cycles
// -----------------------------------------------------------------------------
module vliw_scoreboard #(
    parameter int LANES = 6,
    parameter int NREG  = 32,
    parameter int REGW  = 5,
    parameter int LATW  = 5,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [LANES-1:0]        issue_lane_en,
    input  logic [LANES*REGW-1:0]   issue_dst,
    input  logic [LANES*REGW-1:0]   issue_src1,
    input  logic [LANES*REGW-1:0]   issue_src2,
    input  logic [LANES*LATW-1:0]   issue_lat,
    output logic                    issue_ready,
    output logic                    issue_fire,
    output logic                    illegal,
    output logic [NREG-1:0]         busy_vec,
    output logic [CNTW-1:0]         stall_count
);

    // Per-register countdowns; entry 0 is never loaded and stays zero.
    logic [NREG-1:0][LATW-1:0] cnt_q;
    logic [NREG-1:0][LATW-1:0] cnt_d;
    logic                      illegal_q;
    logic [CNTW-1:0]           stall_q;

    logic raw_hz;
    logic waw_hz;
    logic dup_dst;

    // Busy lookup that treats register 0 and any index >= NREG as never busy,
    // so an out-of-range field cannot index past the countdown array.
    function automatic logic reg_busy(input logic [REGW-1:0] idx,
                                      input logic [NREG-1:0] bv);
        logic hit;
        hit = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (idx == REGW'(r)) begin
                hit = bv[r];
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    // Hazard and duplicate-destination detection over the active lanes.
    always_comb begin
        raw_hz  = 1'b0;
        waw_hz  = 1'b0;
        dup_dst = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (issue_lane_en[k]) begin
                raw_hz = raw_hz
                       | reg_busy(issue_src1[k*REGW +: REGW], busy_vec)
                       | reg_busy(issue_src2[k*REGW +: REGW], busy_vec);
                waw_hz = waw_hz | reg_busy(issue_dst[k*REGW +: REGW], busy_vec);
                for (int j = k + 1; j < LANES; j++) begin
                    if (issue_lane_en[j]
                        && (issue_dst[j*REGW +: REGW] == issue_dst[k*REGW +: REGW])
                        && (issue_dst[k*REGW +: REGW] != '0)) begin
                        dup_dst = 1'b1;
                    end
                end
            end
        end
    end

    assign issue_ready = !rst && !raw_hz && !waw_hz;
    assign issue_fire  = issue_valid && issue_ready;

    // Next countdown state: decrement everything, then overwrite the entries
    // loaded by this cycle's fire. A fired destination cannot already be busy
    // (that would be a WAW stall), so the load never races a live countdown.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LATW'(1)) : '0;
        end
        if (issue_fire && !dup_dst) begin
            for (int k = 0; k < LANES; k++) begin
                if (issue_lane_en[k] && (issue_dst[k*REGW +: REGW] != '0)) begin
                    for (int r = 1; r < NREG; r++) begin
                        if (issue_dst[k*REGW +: REGW] == REGW'(r)) begin
                            cnt_d[r] = (issue_lat[k*LATW +: LATW] == '0)
                                     ? LATW'(1) : issue_lat[k*LATW +: LATW];
                        end
                    end
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            illegal_q <= issue_fire && dup_dst;
            if (issue_valid && !issue_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNTW'(1);
            end
        end
    end

    assign illegal     = illegal_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_vliw_scoreboard.sv
module tb_vliw_scoreboard;

  localparam int LANES = 6;
  localparam int NREG  = 32;
  localparam int REGW  = 5;
  localparam int LATW  = 5;
  localparam int CNTW  = 16;
  localparam int EW    = 1 + CNTW + NREG;
  localparam int SAT   = 65535;

  typedef struct packed {
    logic                        rst;
    logic                        valid;
    logic [LANES-1:0]            en;
    logic [LANES-1:0][REGW-1:0]  dst;
    logic [LANES-1:0][REGW-1:0]  s1;
    logic [LANES-1:0][REGW-1:0]  s2;
    logic [LANES-1:0][LATW-1:0]  lat;
  } bundle_t;

  typedef struct {
    bundle_t b;
    logic    exp_ready;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issue_valid;
  logic [LANES-1:0]      issue_lane_en;
  logic [LANES*REGW-1:0] issue_dst;
  logic [LANES*REGW-1:0] issue_src1;
  logic [LANES*REGW-1:0] issue_src2;
  logic [LANES*LATW-1:0] issue_lat;
  logic                  issue_ready;
  logic                  issue_fire;
  logic                  illegal;
  logic [NREG-1:0]       busy_vec;
  logic [CNTW-1:0]       stall_count;

  always #5 clk = ~clk;

  vliw_scoreboard #(
    .LANES(LANES), .NREG(NREG), .REGW(REGW), .LATW(LATW), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_lane_en(issue_lane_en),
    .issue_dst(issue_dst),
    .issue_src1(issue_src1),
    .issue_src2(issue_src2),
    .issue_lat(issue_lat),
    .issue_ready(issue_ready),
    .issue_fire(issue_fire),
    .illegal(illegal),
    .busy_vec(busy_vec),
    .stall_count(stall_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each register remembers the last cycle number in which it is still busy.
  int          busy_until [NREG];
  int          cyc;
  int          m_stall;
  logic        m_illegal;
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  logic            obs_ready, obs_fire, obs_illegal;
  logic [NREG-1:0] obs_busy;
  logic [CNTW-1:0] obs_stall;

  function automatic logic m_busy(int r);
    return (r != 0) && (r < NREG) && (cyc <= busy_until[r]);
  endfunction

  function automatic logic m_ready(bundle_t b);
    if (b.rst) return 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (b.en[k] && (m_busy(int'(b.s1[k])) || m_busy(int'(b.s2[k])) || m_busy(int'(b.dst[k]))))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic m_dup(bundle_t b);
    int uses [NREG];
    for (int r = 0; r < NREG; r++) uses[r] = 0;
    for (int k = 0; k < LANES; k++)
      if (b.en[k] && b.dst[k] != 0) uses[b.dst[k]]++;
    for (int r = 1; r < NREG; r++)
      if (uses[r] > 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(bundle_t b);
    logic rdy, dup;
    logic [NREG-1:0] bv;
    int l;
    rdy = m_ready(b);
    dup = m_dup(b);
    if (b.rst) begin
      for (int r = 0; r < NREG; r++) busy_until[r] = -1;
      m_stall   = 0;
      m_illegal = 1'b0;
    end else begin
      m_illegal = b.valid && rdy && dup;
      if (b.valid && !rdy && m_stall < SAT) m_stall++;
      if (b.valid && rdy && !dup) begin
        for (int k = 0; k < LANES; k++) begin
          if (b.en[k] && b.dst[k] != 0) begin
            l = int'(b.lat[k]);
            busy_until[b.dst[k]] = cyc + ((l == 0) ? 1 : l);
          end
        end
      end
    end
    cyc++;
    for (int r = 0; r < NREG; r++) bv[r] = m_busy(r);
    exp_q.push_back({m_illegal, CNTW'(m_stall), bv});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(bundle_t b);
    rst           = b.rst;
    issue_valid   = b.valid;
    issue_lane_en = b.en;
    issue_dst     = b.dst;
    issue_src1    = b.s1;
    issue_src2    = b.s2;
    issue_lat     = b.lat;
  endtask

  // Entered just after a rising edge; drives the bundle for one cycle,
  // compares all outputs mid-cycle, then advances the model across the edge.
  task automatic run_cycle(bundle_t b, bit do_check);
    logic [EW-1:0] e;
    logic er;
    drive(b);
    #2;
    obs_ready   = issue_ready;
    obs_fire    = issue_fire;
    obs_illegal = illegal;
    obs_busy    = busy_vec;
    obs_stall   = stall_count;
    er = m_ready(b);
    e  = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else if (do_check) begin
      n_cmp++;
      n_fail++;
      $display("FAIL exp_q: expected queue empty at t=%0t", $time);
    end
    if (do_check) begin
      check("issue_ready", 64'(obs_ready), 64'(er));
      check("issue_fire", 64'(obs_fire), 64'(b.valid & er));
      check("illegal", 64'(obs_illegal), 64'(e[EW-1]));
      check("stall_count", 64'(obs_stall), 64'(e[NREG +: CNTW]));
      check("busy_vec", 64'(obs_busy), 64'(e[NREG-1:0]));
    end
    @(posedge clk);
    model_update(b);
    #1;
  endtask

  function automatic bundle_t mk(logic valid);
    bundle_t b;
    b = '0;
    b.valid = valid;
    return b;
  endfunction

  function automatic bundle_t add_lane(bundle_t b, int k, int d, int a, int c, int l);
    bundle_t r;
    r = b;
    r.en[k]  = 1'b1;
    r.dst[k] = REGW'(d);
    r.s1[k]  = REGW'(a);
    r.s2[k]  = REGW'(c);
    r.lat[k] = LATW'(l);
    return r;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = '0;
    b.rst   = ($urandom_range(0, 199) == 0);
    b.valid = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < LANES; k++) begin
      b.en[k]  = ($urandom_range(0, 2) == 0);
      b.dst[k] = REGW'($urandom_range(0, NREG - 1));
      b.s1[k]  = REGW'($urandom_range(0, NREG - 1));
      b.s2[k]  = REGW'($urandom_range(0, NREG - 1));
      b.lat[k] = LATW'($urandom_range(0, 6));
    end
    return b;
  endfunction

  // ---------------- test ----------------
  vec_t            vecs [10];
  bundle_t         b, rb, idle;
  logic [4:0]      ready_hist, busy_hist;
  int              stalls;
  int              extra;

  initial begin
    idle = mk(1'b0);
    rb   = mk(1'b0);
    rb.rst = 1'b1;

    // Hazard table, evaluated while registers 10 and 11 are busy.
    vecs[0].b = add_lane(mk(0), 0, 1, 10, 0, 2);             vecs[0].exp_ready = 1'b0;
    vecs[1].b = add_lane(mk(0), 2, 2, 3, 11, 2);             vecs[1].exp_ready = 1'b0;
    vecs[2].b = add_lane(mk(0), 3, 10, 1, 2, 2);             vecs[2].exp_ready = 1'b0;
    b = add_lane(mk(0), 1, 3, 1, 2, 2);
    b.dst[0] = 5'd10;
    b.s1[0]  = 5'd11;                                         // lane 0 disabled
    vecs[3].b = b;                                            vecs[3].exp_ready = 1'b1;
    vecs[4].b = add_lane(mk(0), 4, 0, 0, 0, 5);              vecs[4].exp_ready = 1'b1;
    vecs[5].b = add_lane(mk(0), 5, 12, 13, 14, 1);           vecs[5].exp_ready = 1'b1;
    vecs[6].b = mk(0);                                        vecs[6].exp_ready = 1'b1;
    vecs[7].b = add_lane(add_lane(mk(0), 0, 12, 0, 0, 1), 2, 12, 0, 0, 1);
    vecs[7].exp_ready = 1'b1;
    vecs[8].b = add_lane(add_lane(mk(0), 0, 20, 0, 0, 1), 1, 21, 20, 0, 1);
    vecs[8].exp_ready = 1'b1;
    vecs[9].b = add_lane(mk(0), 5, 0, 0, 10, 1);             vecs[9].exp_ready = 1'b0;

    for (int r = 0; r < NREG; r++) busy_until[r] = -1;
    cyc = 0;
    m_stall = 0;
    m_illegal = 1'b0;
    drive(rb);
    @(posedge clk);
    #1;

    // Reset
    run_cycle(rb, 1'b0);
    run_cycle(rb, 1'b1);
    check("reset busy_vec", 64'(obs_busy), 64'd0);
    check("reset stall_count", 64'(obs_stall), 64'd0);
    check("reset illegal", 64'(obs_illegal), 64'd0);
    check("ready low in reset", 64'(obs_ready), 64'd0);

    // Fire dst=5 lat=4, then a dependent read of r5
    run_cycle(add_lane(mk(1), 0, 5, 0, 0, 4), 1'b1);
    check("A fire", 64'(obs_fire), 64'd1);
    b = add_lane(mk(1), 1, 0, 5, 0, 1);
    for (int i = 0; i < 5; i++) begin
      run_cycle(b, 1'b1);
      ready_hist[i] = obs_ready;
      busy_hist[i]  = obs_busy[5];
    end
    check("A ready trace", 64'(ready_hist), 64'b10000);
    check("A busy5 trace", 64'(busy_hist), 64'b01111);
    run_cycle(idle, 1'b1);
    check("A stall_count", 64'(obs_stall), 64'd4);

    // WAW with no bypass: expiry cycle still stalls
    run_cycle(add_lane(mk(1), 3, 7, 0, 0, 25), 1'b1);
    check("B first fire", 64'(obs_fire), 64'd1);
    b = add_lane(mk(1), 0, 7, 0, 0, 1);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(b, 1'b1);
      if (obs_fire) break;
      stalls++;
    end
    check("B waw stall cycles", 64'(stalls), 64'd25);
    run_cycle(idle, 1'b1);
    check("B busy7 after refire", 64'(obs_busy[7]), 64'd1);
    run_cycle(idle, 1'b1);
    check("B busy7 expired", 64'(obs_busy[7]), 64'd0);

    // Duplicate destination
    run_cycle(add_lane(add_lane(mk(1), 0, 9, 0, 0, 3), 2, 9, 0, 0, 3), 1'b1);
    check("C dup fire", 64'(obs_fire), 64'd1);
    run_cycle(idle, 1'b1);
    check("C illegal pulse", 64'(obs_illegal), 64'd1);
    check("C busy9 clear", 64'(obs_busy[9]), 64'd0);
    run_cycle(idle, 1'b1);
    check("C illegal drops", 64'(obs_illegal), 64'd0);

    // Latency 0 behaves as 1
    run_cycle(add_lane(mk(1), 0, 6, 0, 0, 0), 1'b1);
    run_cycle(idle, 1'b1);
    check("D lat0 busy", 64'(obs_busy[6]), 64'd1);
    run_cycle(idle, 1'b1);
    check("D lat0 free", 64'(obs_busy[6]), 64'd0);

    // Table-driven hazard vectors
    run_cycle(add_lane(add_lane(mk(1), 0, 10, 0, 0, 31), 1, 11, 0, 0, 31), 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_cycle(vecs[i].b, 1'b1);
      check($sformatf("table%0d ready", i), 64'(obs_ready), 64'(vecs[i].exp_ready));
    end
    for (int i = 0; i < 25; i++) run_cycle(idle, 1'b1);

    // Reset mid-flight
    run_cycle(add_lane(add_lane(mk(1), 0, 3, 0, 0, 20), 1, 4, 0, 0, 20), 1'b1);
    run_cycle(idle, 1'b1);
    check("E busy 3,4 pending", 64'(obs_busy), 64'h18);
    b = add_lane(rb, 0, 8, 0, 0, 2);
    b.valid = 1'b1;
    run_cycle(b, 1'b1);
    check("E ready in reset", 64'(obs_ready), 64'd0);
    run_cycle(idle, 1'b1);
    check("E busy cleared", 64'(obs_busy), 64'd0);
    for (int i = 0; i < 25; i++) run_cycle(idle, 1'b1);
    check("E no late completion", 64'(obs_busy), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) run_cycle(rand_bundle(), 1'b1);
    run_cycle(rb, 1'b1);

    // Saturation: a self-dependent bundle that stalls 31 of every 32 cycles
    b = add_lane(mk(1), 0, 15, 15, 0, 31);
    extra = 0;
    for (int i = 0; i < 80000; i++) begin
      run_cycle(b, 1'b0);
      if (m_stall == SAT) extra++;
      if (extra >= 50) break;
    end
    run_cycle(b, 1'b1);
    check("stall_count saturated", 64'(obs_stall), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vliw_scoreboard.md
Name: vliw_scoreboard

Overview:
- Parametrised issue-hazard scoreboard for the multi-lane VLIW datapath.
- Sits between instruction decode and the functional-unit issue registers.
- Tracks destination registers with results still in flight in variable-latency units (adder, multiplier, FPA, FPM, logic unit, memory).
- Stalls a bundle on RAW or WAW hazards and rejects bundles that write the same register from two lanes, which the current datapath resolves silently by write-back ordering.

Parameters:
- LANES, 6, issue slots per bundle.
- NREG, 32, architectural registers; R0 is never tracked.
- REGW, 5, register index width; must satisfy 2^REGW >= NREG.
- LATW, 5, per-lane latency field width; maximum latency is 2^LATW-1.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  a bundle is presented this cycle.
- issue_lane_en  in  LANES  per-lane slot-used flags.
- issue_dst  in  LANES*REGW  destination register, lane k at [k*REGW +: REGW].
- issue_src1  in  LANES*REGW  first source register per lane.
- issue_src2  in  LANES*REGW  second source register per lane.
- issue_lat  in  LANES*LATW  unit latency per lane, in cycles.
- issue_ready  out  1  combinational; bundle may fire this cycle.
- issue_fire  out  1  combinational; equals issue_valid & issue_ready.
- illegal  out  1  registered one-cycle pulse; bundle rejected for duplicate destination.
- busy_vec  out  NREG  registered; bit r=1 while register r has a pending write.
- stall_count  out  CNTW  registered; saturating count of stalled cycles.

Behaviour:
- State: one LATW-bit countdown cnt[r] per register. busy_vec[r] = (cnt[r] != 0). cnt[0] is tied to 0.
- Reset (rst=1 at posedge): all cnt cleared, busy_vec=0, stall_count=0, illegal=0. issue_ready is forced 0 while rst=1.
- Reset mid-operation discards every pending entry; no completions are reported afterwards.
- Active lane: issue_lane_en[k]=1. Lanes with enable 0 are ignored entirely.
- Register 0 as a source or destination never causes a hazard and is never marked busy.
- RAW hazard: any active lane has src1 or src2 with busy_vec set.
- WAW hazard: any active lane has dst with busy_vec set.
- issue_ready = !rst & !RAW & !WAW. The duplicate-destination case does not lower issue_ready.
- Duplicate destination: two or more active lanes in the same bundle share a nonzero dst.
  - A fired bundle in this case marks nothing busy.
  - illegal=1 on the next cycle.
  - The bundle counts as consumed.
- Normal fire at posedge T: for each active lane with dst d != 0, cnt[d] <= max(lat,1) at T+1. Latency 0 is treated as 1.
- Countdown: each posedge, every nonzero cnt that was not just loaded decrements by 1.
- Timing for a fire at T with latency L:
  - busy_vec[d] is 1 during cycles T+1 .. T+L.
  - busy_vec[d] is 0 from cycle T+L+1.
  - A dependent bundle can fire at T+L+1 at the earliest.
- No bypass: in the cycle cnt[d]==1, d still counts as busy.
- Simultaneous expiry and re-issue in the same cycle: the bundle stalls, because busy is still 1.
- Intra-bundle reads of another lane's destination do not stall. Sources see pre-bundle values, matching VLIW read-before-write semantics.
- stall_count increments at posedge when issue_valid=1 and issue_ready=0 (rst=0). It holds at 2^CNTW-1 once reached.
- Outputs change only at posedge except issue_ready and issue_fire. No X propagation after reset.

Test Plan:
- Reset → busy_vec=0, stall_count=0, illegal=0. Fire {lane0 dst=5, lat=4} at cycle 1 → busy_vec[5]=1 for cycles 2..5, 0 at cycle 6.
- Dependency stall: after the fire above, present {lane1 src1=5} from cycle 2 → issue_ready=0 for cycles 2..5, fires at cycle 6, stall_count=4.
- WAW plus no-bypass: {lane3 dst=7, lat=25}, then {lane0 dst=7, lat=1} → stalls until cnt[7] expires; the expiry cycle itself still stalls.
- Duplicate destination: lanes 0 and 2 both dst=9, issue_valid=1 → issue_fire=1, illegal=1 next cycle, busy_vec[9]=0.
- Edge cases: lat=0 behaves as lat=1; dst=0 and src=0 never stall; a disabled lane with busy sources does not stall.
- Reset mid-flight with registers 3 and 4 pending → busy_vec=0 next cycle. Hold a stalled bundle 70000 cycles with CNTW=16 → stall_count saturates at 65535.
